// File: rtl/azimuth_sweep_controller.sv
// azimuth_sweep_controller: fills a shadow pattern from a word stream and swaps it into the azimuth generator on each ARP
// Ports: CLK/RST clock and sync active-high reset; ARM run enable; ARP azimuth reference pulse;
//        S_DATA/S_VALID/S_READY word stream in; DATA/EN/TRIG generator drive;
//        UNDERRUN pulse, SWEEP_CNT (wrapping) and UNDERRUN_CNT (saturating) status.
module azimuth_sweep_controller #(
    parameter int SIZE   = 3200,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ARM,
    input  logic              ARP,
    input  logic [WORD_W-1:0] S_DATA,
    input  logic              S_VALID,
    output logic              S_READY,
    output logic [SIZE-1:0]   DATA,
    output logic              EN,
    output logic              TRIG,
    output logic              UNDERRUN,
    output logic [CNT_W-1:0]  SWEEP_CNT,
    output logic [CNT_W-1:0]  UNDERRUN_CNT
);
    localparam int WORDS = SIZE / WORD_W;
    localparam int IW    = WORDS > 1 ? $clog2(WORDS) : 1;
    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
    typedef enum logic [1:0] {PH_IDLE, P1, P2, P3} phase_t;
    state_t          state;
    phase_t          phase;
    logic [IW-1:0]   idx;
    logic [SIZE-1:0] shadow;
    logic            arp_q;
    logic            arp_evt, xfer, last, swap, under;
    assign S_READY = state == FILL;
    always_comb begin
        arp_evt = ARP && !arp_q;
        xfer    = S_VALID && state == FILL;
        last    = xfer && idx == IW'(WORDS - 1);
        swap    = arp_evt && state == FULL && phase == PH_IDLE;
        // a sweep in flight masks ARP; otherwise an ARP without a full shadow is an underrun
        under   = arp_evt && phase == PH_IDLE && state != FULL;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            phase        <= PH_IDLE;
            idx          <= '0;
            shadow       <= '0;
            arp_q        <= 1'b0;
            DATA         <= '0;
            EN           <= 1'b0;
            TRIG         <= 1'b0;
            UNDERRUN     <= 1'b0;
            SWEEP_CNT    <= '0;
            UNDERRUN_CNT <= '0;
        end else begin
            arp_q <= ARP;
            if (!ARM) begin
                state    <= IDLE;
                phase    <= PH_IDLE;
                idx      <= '0;
                EN       <= 1'b0;
                TRIG     <= 1'b0;
                UNDERRUN <= 1'b0;
            end else begin
                for (int i = 0; i < WORDS; i++)
                    if (xfer && idx == IW'(i)) shadow[i*WORD_W +: WORD_W] <= S_DATA;
                if (xfer) idx <= last ? '0 : idx + 1'b1;
                state <= state == IDLE ? FILL : last ? FULL : swap ? FILL : state;
                phase <= swap ? P1 : phase == P1 ? P2 : phase == P2 ? P3 : PH_IDLE;
                if (swap) DATA <= shadow;
                // EN rises after the DATA swap settles and stays up between sweeps
                EN       <= (swap || under) ? 1'b0 : phase == P1 ? 1'b1 : EN;
                TRIG     <= phase == P2;
                UNDERRUN <= under;
                if (phase == P2) SWEEP_CNT <= SWEEP_CNT + 1'b1;
                if (under && UNDERRUN_CNT != '1) UNDERRUN_CNT <= UNDERRUN_CNT + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_azimuth_sweep_controller.sv
// tb_azimuth_sweep_controller: directed and randomized sweeps checked against a transaction-level pattern model
module tb_azimuth_sweep_controller;
    localparam int SIZE   = 3200;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;
    localparam int WORDS  = SIZE / WORD_W;
    logic              CLK = 1'b0;
    logic              RST, ARM, ARP, S_VALID;
    logic [WORD_W-1:0] S_DATA;
    logic              S_READY, EN, TRIG, UNDERRUN;
    logic [SIZE-1:0]   DATA;
    logic [CNT_W-1:0]  SWEEP_CNT, UNDERRUN_CNT;
    int checks = 0;
    int errors = 0;
    logic [WORD_W-1:0] sh [WORDS];
    int                nfill;
    logic [SIZE-1:0]   exp_data;
    logic [CNT_W-1:0]  exp_sweep, exp_under;
    logic              exp_en;

    azimuth_sweep_controller #(.SIZE(SIZE), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ARM(ARM), .ARP(ARP),
        .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
        .DATA(DATA), .EN(EN), .TRIG(TRIG), .UNDERRUN(UNDERRUN),
        .SWEEP_CNT(SWEEP_CNT), .UNDERRUN_CNT(UNDERRUN_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [SIZE-1:0] pattern();
        logic [SIZE-1:0] p;
        for (int i = 0; i < WORDS; i++) p[i*WORD_W +: WORD_W] = sh[i];
        return p;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_data(input string tag);
        int bad = 0;
        for (int i = WORDS - 1; i >= 0; i--)
            if (DATA[i*WORD_W +: WORD_W] !== exp_data[i*WORD_W +: WORD_W]) bad = i;
        checks++;
        assert (DATA === exp_data) else begin
            errors++;
            $error("FAIL %s: word %0d observed %h expected %h", tag, bad,
                   DATA[bad*WORD_W +: WORD_W], exp_data[bad*WORD_W +: WORD_W]);
        end
    endtask

    task automatic chk_reset();
        nfill = 0; exp_data = '0; exp_sweep = '0; exp_under = '0; exp_en = 1'b0;
        chk("rst_ready", S_READY, 0);
        chk("rst_en", EN, 0);
        chk("rst_trig", TRIG, 0);
        chk("rst_underrun", UNDERRUN, 0);
        chk("rst_sweep_cnt", SWEEP_CNT, 0);
        chk("rst_under_cnt", UNDERRUN_CNT, 0);
        chk_data("rst_data");
    endtask

    task automatic push(input logic [WORD_W-1:0] w, input bit with_arp);
        S_VALID = 1'b1;
        S_DATA  = w;
        if (with_arp) ARP = 1'b1;
        chk("ready_fill", S_READY, 1);
        tick();
        S_VALID = 1'b0;
        sh[nfill] = w;
        nfill++;
    endtask

    task automatic fill(input int n, input bit const_en, input logic [WORD_W-1:0] cval);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            push(const_en ? cval : WORD_W'($urandom), 1'b0);
        end
        if (nfill == WORDS) chk("ready_full", S_READY, 0);
    endtask

    task automatic underrun_post();
        if (exp_under != '1) exp_under++;
        exp_en = 1'b0;
        chk("under_pulse", UNDERRUN, 1);
        chk("under_cnt", UNDERRUN_CNT, 32'(exp_under));
        chk("under_en", EN, 0);
        chk("under_trig", TRIG, 0);
        chk("under_ready", S_READY, 32'(nfill < WORDS));
        chk_data("under_data");
        ARP = 1'b0;
        tick();
        chk("under_single", UNDERRUN, 0);
    endtask

    task automatic underrun_ev();
        ARP = 1'b1;
        tick();
        underrun_post();
    endtask

    // pat[k] is the ARP level during cycle N+k; hold_extra keeps pat[3] for more cycles
    task automatic swap(input bit [3:1] pat, input int hold_extra);
        int trigs = 0;
        ARP = 1'b1;
        tick();
        exp_data = pattern();
        nfill = 0;
        ARP = pat[1];
        chk_data("swap_data");
        chk("swap_en_p1", EN, 0);
        chk("swap_trig_p1", TRIG, 0);
        chk("swap_ready_p1", S_READY, 1);
        chk("swap_under_p1", UNDERRUN, 0);
        tick();
        ARP = pat[2];
        chk("swap_en_p2", EN, 1);
        chk("swap_trig_p2", TRIG, 0);
        tick();
        ARP = pat[3];
        exp_sweep++;
        exp_en = 1'b1;
        chk("swap_trig_p3", TRIG, 1);
        chk("swap_en_p3", EN, 1);
        chk("swap_cnt", SWEEP_CNT, 32'(exp_sweep));
        chk("swap_under_p3", UNDERRUN, 0);
        for (int k = 0; k < hold_extra; k++) begin
            tick();
            trigs += int'(TRIG);
            trigs += int'(UNDERRUN);
        end
        if (hold_extra > 0) chk("hold_no_event", 32'(trigs), 0);
        ARP = 1'b0;
        tick();
        chk("swap_trig_end", TRIG, 0);
        chk("swap_en_end", EN, 1);
        chk("swap_under_end", UNDERRUN, 0);
        chk("swap_under_cnt", UNDERRUN_CNT, 32'(exp_under));
    endtask

    initial begin
        RST = 1'b1; ARM = 1'b0; ARP = 1'b0; S_VALID = 1'b0; S_DATA = '0;
        repeat (3) tick();
        RST = 1'b0;
        chk_reset();
        ARM = 1'b1;
        tick();
        chk("arm_ready", S_READY, 1);
        // all-ones sweep
        fill(WORDS, 1'b1, '1);
        swap(3'b000, 0);
        // early ARP, then complete and check word ordering
        fill(40, 1'b0, '0);
        underrun_ev();
        fill(WORDS - 40, 1'b0, '0);
        swap(3'b000, 0);
        // last word and ARP edge in the same cycle
        fill(WORDS - 1, 1'b0, '0);
        push(WORD_W'($urandom), 1'b1);
        underrun_post();
        chk("last_arp_full", S_READY, 0);
        swap(3'b000, 0);
        // retrigger during a sweep, then a 50-cycle ARP
        fill(WORDS, 1'b0, '0);
        swap(3'b010, 0);
        fill(WORDS, 1'b0, '0);
        swap(3'b111, 46);
        // ARM dropped at N+2 of a sweep
        fill(WORDS, 1'b0, '0);
        ARP = 1'b1;
        tick();
        exp_data = pattern();
        nfill = 0;
        chk_data("abort_data");
        ARP = 1'b0;
        tick();
        chk("abort_en_p2", EN, 1);
        ARM = 1'b0;
        tick();
        exp_en = 1'b0;
        chk("abort_trig", TRIG, 0);
        chk("abort_en", EN, 0);
        chk("abort_ready", S_READY, 0);
        chk("abort_cnt", SWEEP_CNT, 32'(exp_sweep));
        chk_data("abort_data_hold");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_trig", TRIG, 0);
        end
        ARM = 1'b1;
        tick();
        chk("rearm_ready", S_READY, 1);
        chk("rearm_en", EN, 0);
        // ARM dropped mid-fill restarts from word 0
        fill(20, 1'b0, '0);
        ARM = 1'b0;
        tick();
        nfill = 0;
        ARM = 1'b1;
        tick();
        fill(WORDS, 1'b0, '0);
        swap(3'b000, 0);
        // randomized sweeps, enough to wrap SWEEP_CNT
        for (int r = 0; r < 12; r++) begin
            int k = $urandom_range(0, WORDS - 1);
            fill(k, 1'b0, '0);
            if ($urandom_range(0, 1) == 1) underrun_ev();
            fill(WORDS - k, 1'b0, '0);
            repeat ($urandom_range(0, 3)) tick();
            swap(3'($urandom), $urandom_range(0, 3));
        end
        // UNDERRUN_CNT saturation
        for (int k = 0; k < 17; k++) underrun_ev();
        chk("under_sat", UNDERRUN_CNT, 32'((1 << CNT_W) - 1));
        // reset mid-fill, then an ARP while IDLE with ARM high
        fill(30, 1'b0, '0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk_reset();
        underrun_ev();
        fill(WORDS, 1'b0, '0);
        swap(3'b000, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/azimuth_sweep_controller.md
Name: azimuth_sweep_controller

Overview:
- Sequences the azimuth signal generator once per antenna sweep.
- Assembles the next sweep's SIZE-bit pattern from a word stream into a shadow register.
- On each azimuth reference pulse (ARP), swaps the shadow into the generator's DATA and issues the EN/TRIG sequence the generator requires.
- Reports sweeps and underruns. Sits between the DMA word stream and the azimuth_signal_generator instance.

Parameters:
- SIZE, 3200, pattern length in bits; must be a multiple of WORD_W.
- WORD_W, 32, stream word width.
- CNT_W, 16, width of the status counters.

Ports:
- CLK  input  1  system clock; everything is synchronous to the rising edge.
- RST  input  1  synchronous, active-high reset.
- ARM  input  1  level; high enables the controller, low returns it to IDLE.
- ARP  input  1  azimuth reference pulse, already synchronous to CLK; any width ≥1 cycle.
- S_DATA  input  WORD_W  stream word.
- S_VALID  input  1  S_DATA is valid.
- S_READY  output  1  controller accepts S_DATA this cycle.
- DATA  output  SIZE  pattern to the generator.
- EN  output  1  generator enable.
- TRIG  output  1  generator trigger, one-cycle pulse.
- UNDERRUN  output  1  one-cycle pulse: an ARP arrived with the shadow incomplete.
- SWEEP_CNT  output  CNT_W  completed swaps, wraps at 2^CNT_W.
- UNDERRUN_CNT  output  CNT_W  underrun events, saturates at all-ones.

Behaviour:
- Reset (RST=1 at an edge): all outputs 0, DATA=0, shadow=0, word index=0, state IDLE, phase IDLE, ARP edge register=0. Reset overrides every other input.
- Constants: WORDS=SIZE/WORD_W (100 by default). Word index is $clog2(WORDS) bits wide.
- Transfer rule: a word transfers when S_VALID && S_READY. Word k (0-based, counted since the shadow was last emptied) writes shadow[k*WORD_W +: WORD_W].
- ARP event: arp_evt = ARP && !arp_q, where arp_q is ARP registered. Only rising edges count.
- Fill FSM states: IDLE, FILL, FULL.
  - IDLE: S_READY=0, EN=0; index held at 0. ARM=1 -> FILL.
  - FILL: S_READY=1. Each transfer increments the index. The transfer of word WORDS-1 -> FULL and the index wraps to 0.
  - FULL: S_READY=0. A swap (below) empties the shadow -> FILL.
  - ARM=0 in any state: next cycle state IDLE, index=0, swap phase aborted, EN=0, TRIG=0. DATA and counters are held.
- Swap sequencer, phases IDLE, P1, P2, P3 (arp_evt in cycle N, state FULL):
  - N+1 (P1): DATA <= shadow; EN=0; fill FSM -> FILL.
  - N+2 (P2): EN=1.
  - N+3 (P3): TRIG=1 for exactly one cycle; SWEEP_CNT+1; EN stays 1 afterwards.
- Underrun: arp_evt in state FILL or IDLE-with-ARM.
  - Cycle N+1: UNDERRUN=1 for one cycle, UNDERRUN_CNT+1 (saturating), EN=0.
  - DATA unchanged; filling continues. The next ARP with a full shadow performs a normal swap.
- Simultaneous events:
  - Last-word transfer in the same cycle as arp_evt counts as an underrun. The word is still stored and the state becomes FULL.
  - arp_evt while the swap phase is P1..P3 is ignored (no underrun, no count).
  - Stream transfers during P1..P3 are allowed; they fill the new, emptied shadow.
- EN timing: EN stays high between sweeps. It falls only in P1, on an underrun, on ARM=0, or on RST.
- Latency: from ARP rising edge (sampled in cycle N) to TRIG is 3 cycles. Shadow full to earliest swap is 1 cycle.

Test Plan:
- Reset, then ARM=1 and stream 100 words of 0xFFFFFFFF, ARP pulse -> DATA all-ones at N+1, EN 0/1/1 at N+1/N+2/N+3, TRIG=1 only at N+3, SWEEP_CNT=1, S_READY=1 again from N+1.
- ARP after only 40 words -> UNDERRUN pulse at N+1, UNDERRUN_CNT=1, EN=0, DATA unchanged. Then finish 60 words, next ARP -> normal swap with the correct word ordering (word 0 at bits [31:0], word 99 at [3199:3168]).
- Last word and ARP rising edge in the same cycle -> underrun counted, state FULL. Next ARP swaps in the complete pattern.
- Second ARP at N+2 during a swap -> ignored: a single TRIG pulse, UNDERRUN_CNT unchanged. ARP held high for 50 cycles -> only one event.
- ARM dropped at N+2 of a swap -> TRIG never asserted, EN=0 next cycle, S_READY=0. Re-ARM refills from word 0.
- Force UNDERRUN_CNT to all-ones and trigger another underrun -> stays 0xFFFF. RST mid-fill -> all outputs 0 on the next cycle.
